acc_datapath_p: RTL and testbench
=================================

// Module: acc_datapath_p
// PURPOSE
//  Parametrised accumulator datapath for the simple CPU. It holds the AR, PC, DR, IR, AC and flag registers.
//  Register traffic uses one internal one-hot-selected bus. Single-cycle ALU ops write the AC directly.
//  MUL is an optional iterative shift-add unit with a start/busy/done handshake.
//  The controller FSM drives every control strobe; memory sits on addr/mem_rdata.
// PARAMETERS
//  DATA_W  16  width of bus, DR, AC, ALU
//  ADDR_W  12  width of AR and PC (taken from bus[ADDR_W-1:0])
//  OPC_W   4   width of IR (taken from bus[DATA_W-1 -: OPC_W])
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  ar_load    in   1        AR <= bus[ADDR_W-1:0]
//  pc_load    in   1        PC <= bus[ADDR_W-1:0]
//  pc_inc     in   1        PC <= PC+1
//  pc_bus     in   1        drive bus from PC (zero-extended)
//  dr_load    in   1        DR <= bus
//  dr_bus     in   1        drive bus from DR
//  mem_bus    in   1        drive bus from mem_rdata
//  mem_rdata  in   DATA_W   memory read data
//  ir_load    in   1        IR <= bus top OPC_W bits
//  alu_sel    in   3        000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT AC, 110 PASS DR, 111 MUL
//  ac_load    in   1        AC <= ALU(AC,DR) (single-cycle ops)
//  ac_inc     in   1        AC <= AC+1
//  ac_clr     in   1        AC <= 0
//  alu_start  in   1        start MUL (alu_sel==111)
//  alu_busy   out  1        MUL in progress
//  alu_done   out  1        1-cycle pulse when the MUL result is written to AC
//  addr       out  ADDR_W   AR contents
//  acc        out  DATA_W   AC contents
//  instr      out  OPC_W    IR contents
//  dr_out     out  DATA_W   DR contents (debug)
//  flags      out  4        {Z,N,C,V}
//  bus_err    out  1        registered: more than one bus driver was active last cycle
// BEHAVIOUR
//  - Reset: every register and output is 0. The FSM is in IDLE.
//  - Bus (combinational):
//    - Exactly one of pc_bus/dr_bus/mem_bus selects its source; none gives 0.
//    - More than one driver: bus=0, loads from the bus proceed with 0, and bus_err=1 on the next cycle.
//  - PC: pc_load beats pc_inc. The increment wraps 2^ADDR_W-1 -> 0.
//  - AC priority: ac_clr > ac_load > ac_inc. ac_inc wraps with no flag change except Z/N.
//  - ADD/SUB: computed at DATA_W+1 bits. C = carry-out (SUB: C = no borrow). V = signed overflow.
//  - Logic ops and PASS: C and V unchanged.
//  - Z and N update on every AC write.
//  - ac_load with alu_sel=111 is a no-op: AC and flags are held.
//  - Register write latency: all register writes take effect at the edge where the strobe is high. Results are visible one cycle later.
//  - MUL FSM, IDLE -> RUN -> DONE -> IDLE:
//    - IDLE: alu_start && alu_sel==111 captures multiplicand=AC, multiplier=DR, and clears the product.
//    - RUN: DATA_W iterations, one bit per cycle; alu_busy=1 throughout.
//    - DONE: AC <= product[DATA_W-1:0]; C = |product[2*DATA_W-1:DATA_W]; V=0; Z/N from AC; alu_done=1 for 1 cycle.
//    - Latency start -> done pulse: DATA_W+1 cycles.
//    - While busy or done: alu_start, ac_load, ac_inc and ac_clr are ignored. DR and other registers may still load; the captured operands are unaffected.
//    - Reset mid-MUL: returns to IDLE at once; AC=0, busy=0, done=0.
// CONFIGURATION
//  - ACC_DATAPATH_MUL_EN defined: MUL unit and FSM present as above.
//  - Undefined: no multiplier logic; alu_busy=alu_done=0 permanently; alu_start is ignored; alu_sel=111 with ac_load holds AC.
// STRUCTURE
//  - Package acc_datapath_pkg:
//    - alu_op_e enum (the 3-bit codes above)
//    - mul_state_e {IDLE,RUN,DONE}
//    - flag bit index constants FLG_Z/N/C/V
//  - Sub-module acc_mul_seq (shift-add multiplier with FSM and handshake), instantiated under the macro.
//  - Bus mux and single-cycle ALU stay in the top module.
// TESTING (DATA_W=16, ADDR_W=12)
//  1. Load DR=0x0002, ac_load PASS -> AC=2; load DR=0x0003, ac_load ADD -> AC=0x0005, Z=0, C=0.
//  2. AC=5, DR=5, SUB -> AC=0, Z=1, C=1. Then AC=0x7FFF, DR=1, ADD -> AC=0x8000, N=1, V=1.
//  3. MUL_EN: AC=7, DR=6, alu_start -> busy for 16 cycles, done on cycle 17, AC=0x002A, C=0.
//     Then 0x0100*0x0100 -> AC=0, C=1, Z=1.
//  4. pc_bus+dr_bus both high, dr_load=1 -> DR=0 and bus_err=1 next cycle.
//     PC=0xFFF plus pc_inc -> PC=0x000.
//  5. Assert rst_n=0 mid-MUL (cycle 8) -> busy=0, AC=0, flags=0 immediately.
//     After release, a new MUL completes normally.
//  6. Macro undefined: alu_start with alu_sel=111 -> busy stays 0 and AC is unchanged.

Source files
------------

// File: rtl/acc_datapath_pkg.sv
// rtl/acc_datapath_pkg.sv - ALU opcodes, multiplier FSM states and flag bit positions for acc_datapath_p
package acc_datapath_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_NOT  = 3'b101,
    ALU_PASS = 3'b110,
    ALU_MUL  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Positions inside the {Z,N,C,V} flag vector
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/acc_mul_seq.sv
// rtl/acc_mul_seq.sv - iterative shift-add multiplier, one multiplier bit per cycle, start/busy/done handshake
module acc_mul_seq
  import acc_datapath_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     mcand,
  input  logic [DATA_W-1:0]     mplier,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W);

  mul_state_e            state, state_nxt;
  logic [2*DATA_W-1:0]   mcand_q;
  logic [2*DATA_W-1:0]   prod_q;
  logic [DATA_W-1:0]     mplier_q;
  logic [CNT_W-1:0]      cnt;
  logic                  last_iter;

  assign last_iter = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operands are latched only in IDLE, so later DR/AC traffic cannot disturb a running product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand_q  <= {{DATA_W{1'b0}}, mcand};
            mplier_q <= mplier;
            prod_q   <= '0;
            cnt      <= '0;
          end
        end
        RUN: begin
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt      <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign product = prod_q;

endmodule

// File: rtl/acc_datapath_p.sv
// rtl/acc_datapath_p.sv - accumulator CPU datapath: AR/PC/DR/IR/AC/flags on one shared bus, optional MUL via ACC_DATAPATH_MUL_EN
module acc_datapath_p
  import acc_datapath_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ar_load,
  input  logic              pc_load,
  input  logic              pc_inc,
  input  logic              pc_bus,
  input  logic              dr_load,
  input  logic              dr_bus,
  input  logic              mem_bus,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              ir_load,
  input  logic [2:0]        alu_sel,
  input  logic              ac_load,
  input  logic              ac_inc,
  input  logic              ac_clr,
  input  logic              alu_start,
  output logic              alu_busy,
  output logic              alu_done,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] acc,
  output logic [OPC_W-1:0]  instr,
  output logic [DATA_W-1:0] dr_out,
  output logic [3:0]        flags,
  output logic              bus_err
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] bus, dr, ac, ac_nxt;
  logic [ADDR_W-1:0] ar, pc;
  logic [OPC_W-1:0]  ir;
  logic [3:0]        flg;
  logic              multi_drv, bus_err_q;
  logic              ac_we, c_nxt, v_nxt;
  logic              mul_busy, mul_done, mul_c;
  logic [DATA_W-1:0] mul_lo;
  logic [DATA_W:0]   sum_x, dif_x;
  alu_op_e           op;

  assign op        = alu_op_e'(alu_sel);
  assign multi_drv = (pc_bus & dr_bus) | (pc_bus & mem_bus) | (dr_bus & mem_bus);

  // Contention collapses the bus to zero rather than picking a winner
  always_comb begin
    bus = '0;
    if (!multi_drv) begin
      if (pc_bus)       bus = DATA_W'(pc);
      else if (dr_bus)  bus = dr;
      else if (mem_bus) bus = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar        <= '0;
      pc        <= '0;
      dr        <= '0;
      ir        <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= multi_drv;
      if (ar_load) ar <= bus[ADDR_W-1:0];
      if (pc_load)     pc <= bus[ADDR_W-1:0];
      else if (pc_inc) pc <= pc + ADDR_W'(1);
      if (dr_load) dr <= bus;
      if (ir_load) ir <= bus[DATA_W-1 -: OPC_W];
    end
  end

  assign sum_x = {1'b0, ac} + {1'b0, dr};
  assign dif_x = {1'b0, ac} + {1'b0, ~dr} + (DATA_W+1)'(1);

  always_comb begin
    ac_we  = 1'b0;
    ac_nxt = ac;
    c_nxt  = flg[FLG_C];
    v_nxt  = flg[FLG_V];
    if (mul_done) begin
      ac_we  = 1'b1;
      ac_nxt = mul_lo;
      c_nxt  = mul_c;
      v_nxt  = 1'b0;
    end else if (!mul_busy) begin
      if (ac_clr) begin
        ac_we  = 1'b1;
        ac_nxt = '0;
      end else if (ac_load) begin
        ac_we = (op != ALU_MUL);
        case (op)
          ALU_ADD: begin
            ac_nxt = sum_x[MSB:0];
            c_nxt  = sum_x[DATA_W];
            v_nxt  = (ac[MSB] == dr[MSB]) && (sum_x[MSB] != ac[MSB]);
          end
          ALU_SUB: begin
            ac_nxt = dif_x[MSB:0];
            c_nxt  = dif_x[DATA_W];
            v_nxt  = (ac[MSB] != dr[MSB]) && (dif_x[MSB] != ac[MSB]);
          end
          ALU_AND:  ac_nxt = ac & dr;
          ALU_OR:   ac_nxt = ac | dr;
          ALU_XOR:  ac_nxt = ac ^ dr;
          ALU_NOT:  ac_nxt = ~ac;
          ALU_PASS: ac_nxt = dr;
          default:  ac_nxt = ac;
        endcase
      end else if (ac_inc) begin
        ac_we  = 1'b1;
        ac_nxt = ac + DATA_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac  <= '0;
      flg <= '0;
    end else if (ac_we) begin
      ac         <= ac_nxt;
      flg[FLG_Z] <= ~|ac_nxt;
      flg[FLG_N] <= ac_nxt[MSB];
      flg[FLG_C] <= c_nxt;
      flg[FLG_V] <= v_nxt;
    end
  end

`ifdef ACC_DATAPATH_MUL_EN
  logic [2*DATA_W-1:0] mul_prod;

  acc_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (alu_start && (op == ALU_MUL)),
    .mcand   (ac),
    .mplier  (dr),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign mul_lo = mul_prod[DATA_W-1:0];
  assign mul_c  = |mul_prod[2*DATA_W-1:DATA_W];
`else
  logic unused_start;
  assign unused_start = alu_start;
  assign mul_busy     = 1'b0;
  assign mul_done     = 1'b0;
  assign mul_lo       = '0;
  assign mul_c        = 1'b0;
`endif

  assign addr     = ar;
  assign acc      = ac;
  assign instr    = ir;
  assign dr_out   = dr;
  assign flags    = flg;
  assign bus_err  = bus_err_q;
  assign alu_busy = mul_busy;
  assign alu_done = mul_done;

endmodule

// File: tb/tb_acc_datapath_p.sv
// tb/tb_acc_datapath_p.sv - directed plus randomized checks of acc_datapath_p against an arithmetic reference model
module tb_acc_datapath_p;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ar_load, pc_load, pc_inc, pc_bus, dr_load, dr_bus, mem_bus, ir_load;
  logic [DW-1:0] mem_rdata;
  logic [2:0]    alu_sel;
  logic          ac_load, ac_inc, ac_clr, alu_start;
  logic          alu_busy, alu_done, bus_err;
  logic [AW-1:0] addr;
  logic [DW-1:0] acc, dr_out;
  logic [OW-1:0] instr;
  logic [3:0]    flags;

  always #5 clk = ~clk;

  acc_datapath_p #(.DATA_W(DW), .ADDR_W(AW), .OPC_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .ar_load(ar_load), .pc_load(pc_load), .pc_inc(pc_inc),
    .pc_bus(pc_bus), .dr_load(dr_load), .dr_bus(dr_bus), .mem_bus(mem_bus),
    .mem_rdata(mem_rdata), .ir_load(ir_load), .alu_sel(alu_sel), .ac_load(ac_load),
    .ac_inc(ac_inc), .ac_clr(ac_clr), .alu_start(alu_start), .alu_busy(alu_busy),
    .alu_done(alu_done), .addr(addr), .acc(acc), .instr(instr), .dr_out(dr_out),
    .flags(flags), .bus_err(bus_err)
  );

  int n_checks = 0;
  int n_err    = 0;
  int m_ac, m_dr;
  bit mz, mn, mc, mv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    ar_load = 0; pc_load = 0; pc_inc = 0; pc_bus = 0; dr_load = 0; dr_bus = 0;
    mem_bus = 0; ir_load = 0; alu_sel = 0; ac_load = 0; ac_inc = 0; ac_clr = 0;
    alu_start = 0; mem_rdata = 0;
  endtask

  function automatic int to_signed(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic void set_zn();
    mz = (m_ac == 0);
    mn = (m_ac >= 32768);
  endfunction

  function automatic void model_alu(input int op);
    int a, b, r, sr;
    a = m_ac;
    b = m_dr;
    case (op)
      0: begin r = a + b; mc = (r > 65535); sr = to_signed(a) + to_signed(b); mv = (sr > 32767) || (sr < -32768); end
      1: begin r = a - b; mc = (a >= b);    sr = to_signed(a) - to_signed(b); mv = (sr > 32767) || (sr < -32768); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: r = b;
      default: return;
    endcase
    m_ac = r & 'hFFFF;
    set_zn();
  endfunction

  function automatic void model_mul(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    m_ac = int'(p & 'hFFFF);
    mc = ((p >> 16) != 0);
    mv = 1'b0;
    set_zn();
  endfunction

  task automatic load_dr(input int v);
    mem_rdata = v[DW-1:0]; mem_bus = 1; dr_load = 1;
    tick();
    mem_bus = 0; dr_load = 0;
    m_dr = v & 'hFFFF;
  endtask

  task automatic do_alu(input int op);
    alu_sel = op[2:0]; ac_load = 1;
    tick();
    ac_load = 0;
    model_alu(op);
  endtask

  task automatic set_ac(input int v);
    load_dr(v);
    do_alu(6);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ac"}, acc, m_ac);
    chk({tag, "_flags"}, flags, {mz, mn, mc, mv});
  endtask

  task automatic read_pc_into_dr();
    pc_bus = 1; dr_load = 1;
    tick();
    pc_bus = 0; dr_load = 0;
  endtask

  initial begin
    idle_ctrl();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", acc, 0);
    chk("rst_flags", flags, 0);
    chk("rst_addr", addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_dr", dr_out, 0);
    chk("rst_busy_done_err", {alu_busy, alu_done, bus_err}, 0);
    rst_n = 1;
    m_ac = 0; m_dr = 0; mz = 0; mn = 0; mc = 0; mv = 0;
    tick();

    load_dr(16'h0002); do_alu(6);
    chk("t1_pass", acc, 16'h0002);
    load_dr(16'h0003); do_alu(0);
    chk("t1_add", acc, 16'h0005);
    chk("t1_zc", {flags[3], flags[1]}, 2'b00);

    load_dr(16'h0005); do_alu(1);
    chk("t2_sub", acc, 16'h0000);
    chk("t2_sub_flags", flags, 4'b1010);
    set_ac(16'h7FFF); load_dr(16'h0001); do_alu(0);
    chk("t2_ovf", acc, 16'h8000);
    chk("t2_ovf_flags", flags, 4'b0101);

    set_ac(16'hFFFF);
    ac_inc = 1; tick(); ac_inc = 0;
    m_ac = 0; set_zn();
    check_model("inc_wrap");

    load_dr(16'h1234); set_ac(16'h00F0);
    ac_clr = 1; ac_load = 1; ac_inc = 1; alu_sel = 3'd6; tick(); idle_ctrl();
    m_ac = 0; set_zn();
    check_model("prio_clr");
    ac_load = 1; ac_inc = 1; alu_sel = 3'd6; tick(); idle_ctrl();
    m_ac = m_dr; set_zn();
    check_model("prio_load");

    for (int i = 0; i < 40; i++) begin
      int k, sel, v;
      k   = int'($urandom_range(0, 9));
      sel = int'($urandom_range(0, 4));
      v   = (sel == 0) ? 'hFFFF : (sel == 1) ? 'h8000 : (sel == 2) ? 'h7FFF : int'($urandom & 'hFFFF);
      load_dr(v);
      if (k < 8) do_alu(k);
      else if (k == 8) begin ac_inc = 1; tick(); ac_inc = 0; m_ac = (m_ac + 1) & 'hFFFF; set_zn(); end
      else begin ac_clr = 1; tick(); ac_clr = 0; m_ac = 0; set_zn(); end
      check_model($sformatf("rnd%0d_op%0d", i, k));
    end

    mem_rdata = 16'hA5C3; mem_bus = 1; ar_load = 1; ir_load = 1; tick(); idle_ctrl();
    chk("ar_load", addr, 12'h5C3);
    chk("ir_load", instr, 4'hA);

    mem_rdata = 16'hFFFF; mem_bus = 1; pc_load = 1; pc_inc = 1; tick(); idle_ctrl();
    read_pc_into_dr();
    chk("pc_load_zext", dr_out, 16'h0FFF);
    pc_inc = 1; tick(); idle_ctrl();
    read_pc_into_dr();
    chk("pc_wrap", dr_out, 16'h0000);

    load_dr(16'h1234);
    pc_bus = 1; dr_bus = 1; dr_load = 1; tick(); idle_ctrl();
    chk("contend_dr", dr_out, 16'h0000);
    chk("contend_err", bus_err, 1'b1);
    tick();
    chk("err_clears", bus_err, 1'b0);
    mem_rdata = 16'hFFFF; pc_bus = 1; dr_bus = 1; mem_bus = 1; ar_load = 1; tick(); idle_ctrl();
    chk("contend3_ar", addr, 12'h000);
    chk("contend3_err", bus_err, 1'b1);
    m_dr = 0;

`ifdef ACC_DATAPATH_MUL_EN
    set_ac(7); load_dr(6);
    alu_sel = 3'd7; alu_start = 1; tick(); idle_ctrl();
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("mul_busy_c%0d", i), {alu_busy, alu_done}, 2'b10);
      if (i == 5) begin
        ac_clr = 1; ac_inc = 1; ac_load = 1; alu_start = 1; alu_sel = 3'd0;
        mem_rdata = 16'h1234; mem_bus = 1; dr_load = 1;
      end
      tick();
      idle_ctrl();
    end
    chk("mul_done_c17", {alu_busy, alu_done}, 2'b01);
    tick();
    chk("mul_done_pulse", alu_done, 1'b0);
    chk("mul_7x6", acc, 16'h002A);
    chk("mul_7x6_flags", flags, 4'b0000);
    chk("mul_dr_loaded", dr_out, 16'h1234);

    set_ac(16'h0100); load_dr(16'h0100);
    alu_sel = 3'd7; alu_start = 1; tick(); idle_ctrl();
    repeat (17) tick();
    chk("mul_hi", acc, 16'h0000);
    chk("mul_hi_flags", flags, 4'b1010);

    set_ac(16'h1111); load_dr(16'h2222);
    alu_sel = 3'd7; alu_start = 1; tick(); idle_ctrl();
    repeat (7) tick();
    chk("mid_busy", alu_busy, 1'b1);
    rst_n = 0;
    #1;
    chk("mid_rst_busy_done", {alu_busy, alu_done}, 2'b00);
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_flags", flags, 0);
    rst_n = 1;
    m_ac = 0; m_dr = 0; mz = 0; mn = 0; mc = 0; mv = 0;
    tick();
    chk("post_rst_idle", {alu_busy, alu_done}, 2'b00);

    for (int i = 0; i < 3; i++) begin
      int a, b;
      a = int'($urandom & 'hFFFF);
      b = int'($urandom & 'hFFFF);
      set_ac(a); load_dr(b);
      alu_sel = 3'd7; alu_start = 1; tick(); idle_ctrl();
      repeat (16) tick();
      chk($sformatf("rmul%0d_done", i), alu_done, 1'b1);
      tick();
      model_mul(a, b);
      check_model($sformatf("rmul%0d", i));
    end
`else
    set_ac(16'h1357); load_dr(16'h0011);
    alu_sel = 3'd7; alu_start = 1; ac_load = 1; tick(); idle_ctrl();
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("nomul_idle%0d", i), {alu_busy, alu_done}, 2'b00);
      tick();
    end
    check_model("nomul_hold");
    chk("nomul_acc", acc, 16'h1357);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
